// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  mem_bus_arbiter
//  Round-robin owner of the shared 16-bit memory bus: fetch vs. load/store,
//  fixed-latency access sequencing, ROM/RAM decode and registered responses.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_bus_arbiter #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] ROM_LIMIT   = 16'h0100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   output logic        f_gnt,
   output logic        f_done,
   output logic [15:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic        d_err,
   output logic [15:0] d_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        MR,
   output logic        MW,
   output logic        rom_en,
   output logic        ram_en,
   output logic        addr_sel_pc,
   output logic        addr_sel_alu,
   output logic        busy
);

   localparam logic [1:0] c_st_idle     = 2'd0;
   localparam logic [1:0] c_st_access   = 2'd1;
   localparam logic [1:0] c_st_complete = 2'd2;
   localparam logic [1:0] c_st_err      = 2'd3;

   localparam logic       c_own_fetch   = 1'b0;
   localparam logic       c_own_data    = 1'b1;
   localparam logic [3:0] c_cnt_last    = 4'(WAIT_CYCLES - 1);

   logic [1:0]  r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_owner, w_owner_nxt;
   logic        r_last_owner, w_last_nxt;
   logic        r_we, w_we_nxt;
   logic [15:0] r_addr, w_addr_nxt;
   logic [15:0] r_wdata, w_wdata_nxt;

   logic        w_grant, w_win_data, w_last_beat, w_access_nxt, w_rom_hit;

   logic        w_f_gnt, w_f_done, w_d_gnt, w_d_done, w_d_err;
   logic [15:0] w_f_rdata, w_d_rdata, w_mem_addr, w_mem_wdata;
   logic        w_mr, w_mw, w_rom_en, w_ram_en, w_sel_pc, w_sel_alu, w_busy;

   // On contention the requester that did not own the previous access wins.
   assign w_grant     = (r_state == c_st_idle) && (f_req || d_req);
   assign w_win_data  = d_req && (!f_req || (r_last_owner == c_own_fetch));
   assign w_last_beat = (r_state == c_st_access) && (r_cnt == c_cnt_last);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= c_st_idle;
         r_cnt        <= 4'd0;
         r_owner      <= c_own_fetch;
         r_last_owner <= c_own_fetch;
         r_we         <= 1'b0;
         r_addr       <= 16'h0000;
         r_wdata      <= 16'h0000;
         f_gnt        <= 1'b0;
         f_done       <= 1'b0;
         f_rdata      <= 16'h0000;
         d_gnt        <= 1'b0;
         d_done       <= 1'b0;
         d_err        <= 1'b0;
         d_rdata      <= 16'h0000;
         mem_addr     <= 16'h0000;
         mem_wdata    <= 16'h0000;
         MR           <= 1'b0;
         MW           <= 1'b0;
         rom_en       <= 1'b0;
         ram_en       <= 1'b0;
         addr_sel_pc  <= 1'b0;
         addr_sel_alu <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_nxt;
         r_we         <= w_we_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
         f_gnt        <= w_f_gnt;
         f_done       <= w_f_done;
         f_rdata      <= w_f_rdata;
         d_gnt        <= w_d_gnt;
         d_done       <= w_d_done;
         d_err        <= w_d_err;
         d_rdata      <= w_d_rdata;
         mem_addr     <= w_mem_addr;
         mem_wdata    <= w_mem_wdata;
         MR           <= w_mr;
         MW           <= w_mw;
         rom_en       <= w_rom_en;
         ram_en       <= w_ram_en;
         addr_sel_pc  <= w_sel_pc;
         addr_sel_alu <= w_sel_alu;
         busy         <= w_busy;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_owner;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      case (r_state)
         c_st_idle: begin
            if (w_grant) begin
               w_owner_nxt = w_win_data;
               w_last_nxt  = w_win_data;
               w_addr_nxt  = w_win_data ? d_addr : f_addr;
               w_we_nxt    = w_win_data && d_we;
               w_wdata_nxt = w_win_data ? d_wdata : r_wdata;
               w_cnt_nxt   = 4'd0;
               // Stores into ROM never reach the bus.
               if (w_win_data && d_we && (d_addr < ROM_LIMIT))
                  w_state_nxt = c_st_err;
               else
                  w_state_nxt = c_st_access;
            end
         end
         c_st_access: begin
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = c_st_complete;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
            end
         end
         c_st_complete: w_state_nxt = c_st_idle;
         c_st_err:      w_state_nxt = c_st_idle;
         default:       w_state_nxt = c_st_idle;
      endcase
   end

   // Outputs are decoded from the next state so that every port is a flop.
   always_comb begin
      w_access_nxt = (w_state_nxt == c_st_access);
      w_rom_hit    = (w_addr_nxt < ROM_LIMIT);
      w_f_gnt      = w_grant && !w_win_data;
      w_d_gnt      = w_grant && w_win_data;
      w_mr         = w_access_nxt && !w_we_nxt;
      w_mw         = w_access_nxt && w_we_nxt;
      w_rom_en     = w_access_nxt && w_rom_hit;
      w_ram_en     = w_access_nxt && !w_rom_hit;
      w_sel_pc     = w_access_nxt && (w_owner_nxt == c_own_fetch);
      w_sel_alu    = w_access_nxt && (w_owner_nxt == c_own_data);
      w_mem_addr   = w_access_nxt ? w_addr_nxt : mem_addr;
      w_mem_wdata  = w_access_nxt ? w_wdata_nxt : mem_wdata;
      w_f_done     = w_last_beat && (r_owner == c_own_fetch);
      w_d_done     = (w_last_beat && (r_owner == c_own_data)) || (r_state == c_st_err);
      w_d_err      = (r_state == c_st_err);
      w_f_rdata    = (w_last_beat && !r_we && (r_owner == c_own_fetch)) ? mem_rdata : f_rdata;
      w_d_rdata    = (w_last_beat && !r_we && (r_owner == c_own_data)) ? mem_rdata : d_rdata;
      w_busy       = (w_state_nxt != c_st_idle);
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
//  tb_mem_bus_arbiter
//  Directed and randomized transactions checked against a transaction-level
//  model of the arbiter (round-robin owner, fixed access timeline, rdata).
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;

   localparam int          c_wait      = 2;
   localparam logic [15:0] c_rom_limit = 16'h0100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = 16'h0000;
   logic        f_gnt, f_done;
   logic [15:0] f_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] d_wdata = 16'h0000;
   logic        d_gnt, d_done, d_err;
   logic [15:0] d_rdata;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic        MR, MW, rom_en, ram_en, addr_sel_pc, addr_sel_alu, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cyc = 0;

   // Model state: owner of the previous access and the last word returned to each side.
   bit          m_last = 1'b0;
   logic [15:0] m_frdata = 16'h0000;
   logic [15:0] m_drdata = 16'h0000;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   mem_bus_arbiter #(.WAIT_CYCLES(c_wait), .ROM_LIMIT(c_rom_limit)) dut (
      .clock(clock), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .MR(MR), .MW(MW), .rom_en(rom_en), .ram_en(ram_en),
      .addr_sel_pc(addr_sel_pc), .addr_sel_alu(addr_sel_alu), .busy(busy)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 4))
         0:       return 16'($urandom_range(0, 255));
         1:       return 16'hFFFF;
         2:       return 16'h00FF;
         3:       return 16'h0100;
         default: return 16'($urandom);
      endcase
   endfunction

   // Called at a sample point of an idle cycle; returns at the sample point of the
   // next idle cycle. The losing requester keeps its request raised.
   task automatic do_txn(input bit fq, input bit dq, input bit we,
                         input logic [15:0] fa, input logic [15:0] da,
                         input logic [15:0] wd, input logic [15:0] rd, input bit wdp);
      bit          win, is_err, ewe, rom;
      logic [15:0] ea;
      f_req = fq;  d_req = dq;  f_addr = fa;  d_addr = da;  d_we = we;  d_wdata = wd;
      win    = (fq && dq) ? !m_last : dq;
      m_last = win;
      is_err = win && we && (da < c_rom_limit);
      ea     = win ? da : fa;
      ewe    = win && we;
      rom    = (ea < c_rom_limit);
      tick();
      chk("f_gnt", f_gnt, !win);
      chk("d_gnt", d_gnt, win);
      chk("busy_gnt", busy, 1'b1);
      if (win) begin
         d_req = 1'b0;  d_addr = 16'($urandom);  d_wdata = 16'($urandom);  d_we = 1'($urandom);
      end else begin
         f_req = 1'b0;  f_addr = 16'($urandom);
      end
      if (is_err) begin
         chk("err_mw", MW, 1'b0);
         chk("err_mr", MR, 1'b0);
         tick();
         chk("err_d_done", d_done, 1'b1);
         chk("err_d_err", d_err, 1'b1);
         chk("err_busy", busy, 1'b0);
         chk("err_mw_after", MW, 1'b0);
         chk("err_d_rdata", d_rdata, m_drdata);
         return;
      end
      for (int k = 0; k < c_wait; k++) begin
         if (k > 0) begin
            tick();
            chk("gnt_pulse", {15'd0, f_gnt | d_gnt}, 16'd0);
         end
         chk("acc_mr", MR, !ewe);
         chk("acc_mw", MW, ewe);
         chk("acc_rom_en", rom_en, rom);
         chk("acc_ram_en", ram_en, !rom);
         chk("acc_sel_pc", addr_sel_pc, !win);
         chk("acc_sel_alu", addr_sel_alu, win);
         chk("acc_mem_addr", mem_addr, ea);
         if (ewe) chk("acc_mem_wdata", mem_wdata, wd);
         chk("acc_busy", busy, 1'b1);
         chk("acc_no_done", {15'd0, f_done | d_done}, 16'd0);
         if (wdp && k == 0) begin
            d_req = 1'b1;  d_we = 1'b0;  d_addr = 16'($urandom);
         end
         mem_rdata = (k == c_wait - 1) ? rd : 16'($urandom);
      end
      tick();
      done_cyc = cyc;
      if (!ewe) begin
         if (win) m_drdata = rd;
         else     m_frdata = rd;
      end
      chk("cpl_f_done", f_done, !win);
      chk("cpl_d_done", d_done, win);
      chk("cpl_d_err", d_err, 1'b0);
      chk("cpl_strobes", {14'd0, MR, MW}, 16'd0);
      chk("cpl_selects", {12'd0, rom_en, ram_en, addr_sel_pc, addr_sel_alu}, 16'd0);
      chk("cpl_mem_addr", mem_addr, ea);
      chk("cpl_busy", busy, 1'b1);
      chk("cpl_f_rdata", f_rdata, m_frdata);
      chk("cpl_d_rdata", d_rdata, m_drdata);
      if (wdp) d_req = 1'b0;
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_no_gnt", {15'd0, f_gnt | d_gnt}, 16'd0);
      chk("idle_no_done", {15'd0, f_done | d_done}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d1, d2, d3;
      bit fq, dq;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_gnt", {14'd0, f_gnt, d_gnt}, 16'd0);
      chk("rst_done", {13'd0, f_done, d_done, d_err}, 16'd0);
      chk("rst_strobes", {14'd0, MR, MW}, 16'd0);
      chk("rst_selects", {12'd0, rom_en, ram_en, addr_sel_pc, addr_sel_alu}, 16'd0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
      chk("rst_f_rdata", f_rdata, 16'h0000);
      chk("rst_d_rdata", d_rdata, 16'h0000);
      @(posedge clock);
      #1 reset = 1'b1;

      do_txn(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 16'hA5C3, 1'b0);
      chk("t1_f_rdata", f_rdata, 16'hA5C3);

      // Contention right after the first fetch: expect data, fetch, data.
      do_txn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0300, 16'h0000, 16'h1111, 1'b0);
      d1 = done_cyc;
      chk("sim_first_data", {15'd0, m_last}, 16'd1);
      do_txn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0300, 16'h0000, 16'h2222, 1'b0);
      d2 = done_cyc;
      do_txn(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0300, 16'h0000, 16'h3333, 1'b0);
      d3 = done_cyc;
      chk("sim_gap1", 16'(d2 - d1), 16'd4);
      chk("sim_gap2", 16'(d3 - d2), 16'd4);
      f_req = 1'b0;
      tick();

      do_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200, 16'h1234, 16'h0BAD, 1'b0);
      do_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
      do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, 16'h7E57, 1'b0);

      do_txn(1'b1, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 16'hC0DE, 1'b1);
      tick();
      chk("wd_no_gnt", d_gnt, 1'b0);
      chk("wd_no_done", d_done, 1'b0);
      chk("wd_busy", busy, 1'b0);

      for (int i = 0; i < 40; i++) begin
         fq = 1'($urandom);
         dq = 1'($urandom);
         if (!fq && !dq) dq = 1'b1;
         do_txn(fq, dq, 1'($urandom), pick_addr(), pick_addr(), 16'($urandom), 16'($urandom), 1'b0);
      end
      f_req = 1'b0;
      d_req = 1'b0;
      tick();

      // Abort a load in its second access cycle.
      do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0300, 16'h0000, 16'h5A5A, 1'b0);
      d_req = 1'b1;  d_we = 1'b0;  d_addr = 16'h0400;
      tick();
      chk("rst_mid_gnt", d_gnt, 1'b1);
      d_req = 1'b0;
      tick();
      chk("rst_mid_mr_before", MR, 1'b1);
      reset = 1'b0;
      #2;
      chk("rst_mid_mr", MR, 1'b0);
      chk("rst_mid_d_done", d_done, 1'b0);
      chk("rst_mid_d_rdata", d_rdata, 16'h0000);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_mem_addr", mem_addr, 16'h0000);
      m_last   = 1'b0;
      m_frdata = 16'h0000;
      m_drdata = 16'h0000;
      tick();
      chk("rst_hold_done", d_done, 1'b0);
      reset = 1'b1;
      tick();

      do_txn(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h9876, 1'b0);
      do_txn(1'b1, 1'b1, 1'b1, 16'h0100, 16'hFFFF, 16'h4321, 16'h0000, 1'b0);
      f_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
